pipeline_ctrl: RTL

Central sequencer for the five-stage pipeline register banks (stages PS1..PS4). Each cycle it generates the PC write enable and the per-stage register enables and flushes. It covers four cases: load-use stalls, taken-branch flushes, multi-cycle data-memory waits with timeout, and a syscall halt/resume state. It also keeps saturating stall and flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 50 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 19 +
 rtl/pipeline_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its hazard unit.
package pipeline_ctrl_pkg;

  // Width of the registered state and of a register-file index.
  localparam int ST_BIT    = 2;
  localparam int REG_IDX_W = 5;

  typedef enum logic [ST_BIT-1:0] {
    ST_RUN  = 2'd0,
    ST_MEMW = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // One bundle for the PC/stage enables and the bubble-insertion flushes.
  typedef struct packed {
    logic pc_en;
    logic en_ps1;
    logic en_ps2;
    logic en_ps3;
    logic en_ps4;
    logic flush_ps1;
    logic flush_ps2;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '0;

  // Normal flowing-pipeline controls: a taken branch squashes IF/ID and ID/EX
  // and beats a load-use stall; a load-use stall holds PC and IF/ID and
  // pushes one bubble into ID/EX.
  function automatic ctrl_t run_ctrl(input logic branch, input logic lu);
    ctrl_t c;
    c.pc_en     = 1'b1;
    c.en_ps1    = 1'b1;
    c.en_ps2    = 1'b1;
    c.en_ps3    = 1'b1;
    c.en_ps4    = 1'b1;
    c.flush_ps1 = 1'b0;
    c.flush_ps2 = 1'b0;
    if (branch) begin
      c.flush_ps1 = 1'b1;
      c.flush_ps2 = 1'b1;
    end else if (lu) begin
      c.pc_en     = 1'b0;
      c.en_ps1    = 1'b0;
      c.flush_ps2 = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detection from the ID and EX register fields.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rs_i,
  input  logic                 id_uses_rt_i,
  input  logic                 ex_mem_read_i,
  input  logic [REG_IDX_W-1:0] ex_wreg_i,
  output logic                 lu_o
);

  // A load into r0 never creates a dependency, so it is excluded.
  assign lu_o = ex_mem_read_i && (ex_wreg_i != '0) &&
                ((id_uses_rs_i && (id_rs_i == ex_wreg_i)) ||
                 (id_uses_rt_i && (id_rt_i == ex_wreg_i)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: stage enables/flushes, memory-wait timeout, syscall
// halt/resume and saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_wreg,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 pc_en,
  output logic                 en_ps1,
  output logic                 en_ps2,
  output logic                 en_ps3,
  output logic                 en_ps4,
  output logic                 flush_ps1,
  output logic                 flush_ps2,
  output logic                 halted,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               guard_q, guard_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               lu;
  ctrl_t              ctrl, ctrl_out;
  logic               stall_inc;

  hazard_detect u_hazard (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rs_i (id_uses_rs),
    .id_uses_rt_i (id_uses_rt),
    .ex_mem_read_i(ex_mem_read),
    .ex_wreg_i    (ex_wreg),
    .lu_o         (lu)
  );

  // Next-state and same-cycle control generation.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    tmo_d     = tmo_q;
    mem_err_d = mem_err_q;
    guard_d   = 1'b0;
    ctrl      = CTRL_FREEZE;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          state_d = ST_MEMW;
          tmo_d   = TMO_W'(1);
        end else if (halt_req && !guard_q) begin
          state_d = ST_HALT;
        end else begin
          ctrl = run_ctrl(branch_taken, lu);
        end
      end
      ST_MEMW: begin
        // Halt is not evaluated on the completing cycle; branch/lu are.
        if (mem_ack) begin
          ctrl    = run_ctrl(branch_taken, lu);
          state_d = ST_RUN;
        end else if (tmo_q == TMO_MAX) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HALT: begin
        // The guard masks the halt_req still sitting in the last stage.
        if (resume) begin
          state_d = ST_RUN;
          guard_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating performance counter updates.
  always_comb begin
    stall_inc   = (state_q != ST_HALT) && !ctrl.pc_en;
    stall_cnt_d = (stall_inc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (ctrl.flush_ps1 && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  // State, timeout, guard, sticky error and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      guard_q     <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      guard_q     <= guard_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced quiet while reset is asserted, independent of clk.
  assign ctrl_out  = rst ? CTRL_FREEZE : ctrl;
  assign pc_en     = ctrl_out.pc_en;
  assign en_ps1    = ctrl_out.en_ps1;
  assign en_ps2    = ctrl_out.en_ps2;
  assign en_ps3    = ctrl_out.en_ps3;
  assign en_ps4    = ctrl_out.en_ps4;
  assign flush_ps1 = ctrl_out.flush_ps1;
  assign flush_ps2 = ctrl_out.flush_ps2;
  assign halted    = !rst && (state_q == ST_HALT);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
